pipe_exe_stage: RTL

Execute stage of the five-stage pipelined CPU, fused with the EXE/MEM pipeline register. It consumes the ID/EXE register outputs and selects ALU operands. It computes the ALU or jump-link result and registers the control and data needed by the MEM stage. An iterative 32-cycle multiplier stalls the front of the pipeline while a MUL occupies EXE and inserts bubbles into MEM.

---
 rtl/pipe_pkg.sv | 26 ++
 rtl/pipe_mul_iter.sv | 81 ++++++++
 rtl/pipe_exe_stage.sv | 107 ++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline execute stage: ALU opcodes, multiplier
// iteration count and FSM state encoding, and the jump-and-link destination.
package pipe_pkg;

  localparam logic [3:0] ALUC_ADD = 4'b0000;
  localparam logic [3:0] ALUC_SUB = 4'b0100;
  localparam logic [3:0] ALUC_AND = 4'b0001;
  localparam logic [3:0] ALUC_OR  = 4'b0101;
  localparam logic [3:0] ALUC_XOR = 4'b0010;
  localparam logic [3:0] ALUC_LUI = 4'b0110;
  localparam logic [3:0] ALUC_SLL = 4'b0011;
  localparam logic [3:0] ALUC_SRL = 4'b0111;
  localparam logic [3:0] ALUC_SRA = 4'b1111;
  localparam logic [3:0] ALUC_MUL = 4'b1011;

  localparam int         MUL_ITERS = 32;
  localparam int         MUL_CNT_W = 5;
  localparam logic [4:0] JAL_RN    = 5'd31;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/pipe_mul_iter.sv
// Iterative shift-add multiplier, one multiplier bit per clock; yields the low
// 32 bits of a*b. Only built when PIPE_MULDIV_EN is defined.
module pipe_mul_iter
  import pipe_pkg::*;
(
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);

  mul_state_e           state_r, state_next_s;
  logic [31:0]          a_r, b_r, acc_r;
  logic [MUL_CNT_W-1:0] cnt_r;

  // FSM state register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r <= MUL_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state decode
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      MUL_IDLE: begin
        if (start) state_next_s = MUL_BUSY;
        else       state_next_s = MUL_IDLE;
      end
      MUL_BUSY: begin
        if (cnt_r == MUL_CNT_W'(MUL_ITERS - 1)) state_next_s = MUL_DONE;
        else                                    state_next_s = MUL_BUSY;
      end
      MUL_DONE: state_next_s = MUL_IDLE;
      default:  state_next_s = MUL_IDLE;
    endcase
  end

  // Operand shifters, accumulator and iteration counter
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      a_r   <= 32'd0;
      b_r   <= 32'd0;
      acc_r <= 32'd0;
      cnt_r <= '0;
    end else begin
      case (state_r)
        MUL_IDLE: begin
          if (start) begin
            a_r   <= a;
            b_r   <= b;
            acc_r <= 32'd0;
            cnt_r <= '0;
          end
        end
        MUL_BUSY: begin
          acc_r <= acc_r + (b_r[0] ? a_r : 32'd0);
          a_r   <= {a_r[30:0], 1'b0};
          b_r   <= {1'b0, b_r[31:1]};
          cnt_r <= cnt_r + 1'b1;
        end
        default: begin
          acc_r <= acc_r;
        end
      endcase
    end
  end

  // The stall is released while reset is held so upstream never freezes in reset.
  assign busy    = resetn & (((state_r == MUL_IDLE) & start) | (state_r == MUL_BUSY));
  assign done    = (state_r == MUL_DONE);
  assign product = acc_r;

endmodule

// File: rtl/pipe_exe_stage.sv
// Execute stage fused with the EXE/MEM register. Define PIPE_MULDIV_EN to
// build the iterative multiplier; otherwise MUL yields 0 with no stall.
module pipe_exe_stage
  import pipe_pkg::*;
(
  input  logic        clock,
  input  logic        resetn,
  input  logic        ewreg,
  input  logic        em2reg,
  input  logic        ewmem,
  input  logic [3:0]  ealuc,
  input  logic        ealuimm,
  input  logic        eshift,
  input  logic        ejal,
  input  logic [31:0] ea,
  input  logic [31:0] eb,
  input  logic [31:0] eimm,
  input  logic [31:0] epc4,
  input  logic [4:0]  ern0,
  output logic [31:0] ealu,
  output logic [4:0]  ern,
  output logic        estall,
  output logic        mwreg,
  output logic        mm2reg,
  output logic        mwmem,
  output logic [31:0] malu,
  output logic [31:0] mb,
  output logic [4:0]  mrn
);

  logic [31:0] opa_s, opb_s, alu_s, mul_res_s;
  logic        stall_s;

  assign opa_s = eshift  ? {27'd0, eimm[10:6]} : ea;
  assign opb_s = ealuimm ? eimm : eb;

`ifdef PIPE_MULDIV_EN
  logic        mul_done_s;
  logic [31:0] mul_prod_s;

  pipe_mul_iter u_mul (
    .clock   (clock),
    .resetn  (resetn),
    .start   (ealuc == ALUC_MUL),
    .a       (opa_s),
    .b       (opb_s),
    .busy    (stall_s),
    .done    (mul_done_s),
    .product (mul_prod_s)
  );

  assign mul_res_s = mul_done_s ? mul_prod_s : 32'd0;
`else
  assign stall_s   = 1'b0;
  assign mul_res_s = 32'd0;
`endif

  // ALU decode; bit 3 only distinguishes the shift/MUL group
  always_comb begin
    alu_s = 32'd0;
    case (ealuc[2:0])
      ALUC_ADD[2:0]: alu_s = opa_s + opb_s;
      ALUC_SUB[2:0]: alu_s = opa_s - opb_s;
      ALUC_AND[2:0]: alu_s = opa_s & opb_s;
      ALUC_OR[2:0]:  alu_s = opa_s | opb_s;
      ALUC_XOR[2:0]: alu_s = opa_s ^ opb_s;
      ALUC_LUI[2:0]: alu_s = {opb_s[15:0], 16'd0};
      ALUC_SLL[2:0]: begin
        if (ealuc[3]) alu_s = mul_res_s;
        else          alu_s = opb_s << opa_s[4:0];
      end
      ALUC_SRL[2:0]: begin
        if (ealuc[3]) alu_s = $unsigned($signed(opb_s) >>> opa_s[4:0]);
        else          alu_s = opb_s >> opa_s[4:0];
      end
      default: alu_s = 32'd0;
    endcase
  end

  assign ealu   = ejal ? (epc4 + 32'd4) : alu_s;
  assign ern    = ejal ? JAL_RN : ern0;
  assign estall = stall_s;

  // EXE/MEM register; a stall loads a bubble and holds the data fields
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mwreg  <= 1'b0;
      mm2reg <= 1'b0;
      mwmem  <= 1'b0;
      malu   <= 32'd0;
      mb     <= 32'd0;
      mrn    <= 5'd0;
    end else if (stall_s) begin
      mwreg  <= 1'b0;
      mm2reg <= 1'b0;
      mwmem  <= 1'b0;
    end else begin
      mwreg  <= ewreg;
      mm2reg <= em2reg;
      mwmem  <= ewmem;
      malu   <= ealu;
      mb     <= eb;
      mrn    <= ern;
    end
  end

endmodule
